barycentric_seq: RTL
====================

# barycentric_seq

Parametrised, resource-shared barycentric coefficient unit for the rasteriser. It accepts one point and triangle per valid/ready handshake and computes the three signed edge functions and the full-triangle area on a single time-multiplexed multiplier pair. It then runs three bit-serial restoring dividers in parallel and holds the result until the downstream stage accepts it. The block trades throughput for area, and adds backpressure, degenerate-triangle detection, saturation and an inside flag.

## Interface
- COORD_WIDTH, 17: signed two's-complement width of each coordinate.
- FRAC_BITS, 16: fractional bits of each coefficient.
- INT_BITS, 2: integer bits of each coefficient; COEFF_WIDTH = FRAC_BITS + INT_BITS.
- clk_in  input  1  clock.
- rst_in  input  1  reset; one clock; reset is asynchronous and active-high.
- valid_in  input  1  input transaction valid.
- ready_out  output  1  block can accept; combinational, equals (state == IDLE).
- point_in  input  [1:0][COORD_WIDTH-1:0]  point; [0]=x, [1]=y.
- vertices_in  input  [2:0][1:0][COORD_WIDTH-1:0]  v0, v1, v2.
- valid_out  output  1  result valid.
- ready_in  input  1  downstream accepts the result.
- coeffs_out  output  [2:0][COEFF_WIDTH-1:0]  |c0|, |c1|, |c2| in unsigned fixed point.
- coeffs_negative_out  output  [2:0]  sign of each coefficient.
- inside_out  output  1  point is inside the triangle or on its edge.
- degenerate_out  output  1  triangle area is zero.

## Operation
- Edge function: E(p,a,b) = (b.x-a.x)*(p.y-a.y) - (b.y-a.y)*(p.x-a.x), signed, computed exactly in 2*COORD_WIDTH+3 bits.
- F = E(v0,v1,v2).
- E0 = E(p,v1,v2), E1 = E(p,v2,v0), E2 = E(p,v0,v1). Coefficient ck = Ek/F.
- ck magnitude = floor(|Ek| * 2^FRAC_BITS / |F|).
  - Saturates to 2^COEFF_WIDTH-1 iff |Ek| >= |F| << INT_BITS.
- coeffs_negative_out[k] = (Ek != 0) && (sign(Ek) XOR sign(F)).
- inside_out = !degenerate && no coefficient negative.
- Both vertex windings therefore give identical outputs.
- FSM states and transitions:
  - IDLE: on valid_in && ready_out, capture the inputs and go to AREA.
  - AREA: 4 cycles, one product pair per cycle, in order F, E0, E1, E2.
  - PREP: 1 cycle. Take absolute values, compute signs and overflow flags, load the dividers.
    - If F == 0: set degenerate_out=1, coeffs=0, all negative flags=0, inside_out=0, and go straight to DONE.
  - DIV: COEFF_WIDTH cycles. Three restoring dividers each produce one quotient bit per cycle, MSB first. A saturated channel forces all ones.
  - DONE: valid_out=1, outputs stable. On ready_in go to IDLE.
- Reset, including mid-operation: state goes to IDLE immediately.
  - Reset values: valid_out=0, coeffs_out=0, coeffs_negative_out=0, inside_out=0, degenerate_out=0.
  - ready_out=1 while in IDLE, including during reset.
  - Any in-flight transaction is discarded; no partial result is ever emitted.

## Timing
- Handshake accepted in cycle t:
  - AREA occupies t+1..t+4.
  - PREP occupies t+5.
  - DIV occupies t+6..t+5+COEFF_WIDTH.
  - valid_out rises in cycle t+6+COEFF_WIDTH (t+24 with defaults).
- Degenerate triangle: valid_out rises in cycle t+6.
- Output handshake in cycle u (valid_out && ready_in): valid_out=0 and ready_out=1 in cycle u+1.
  - No same-cycle pass-through.
  - Peak throughput is one transaction per COEFF_WIDTH+7 cycles.
- valid_in while ready_out=0 is ignored; the source must hold it.
- The input buses are sampled only on the accept cycle; later changes have no effect.
- Outputs do not change while valid_out=1 && ready_in=0, for any stall length.

## Test plan
- Defaults, v0=(0,0), v1=(4,0), v2=(0,4), p=(1,1), ready_in=1 → valid_out exactly 24 cycles after accept.
  - coeffs = {16384, 16384, 32768} (c2, c1, c0); negative flags = 0.
  - inside_out=1, degenerate_out=0.
- Same triangle, p=(-1,1) → c0=65536, c1=16384 with negative flag 1, c2=16384; inside_out=0.
- Winding swapped (v1 and v2 exchanged), p=(1,1) → same magnitudes with c1 and c2 swapped; all negative flags 0; inside_out=1.
- p=(40,0) on the first triangle → c0 saturates to 262143 with negative flag 1; no wrap-around on any channel.
- Collinear triangle v0=(0,0), v1=(1,1), v2=(2,2) → valid_out 6 cycles after accept; degenerate_out=1; coeffs=0; inside_out=0.
- Backpressure and reset:
  - Hold ready_in=0 for 10 cycles → outputs stable, ready_out=0, and a waiting valid_in is not accepted until one cycle after the output handshake.
  - Assert rst_in during DIV → valid_out stays 0, ready_out=1, and the next transaction produces a correct result.

Source files
------------

// File: rtl/barycentric_seq.sv
// Barycentric coefficient unit: one shared multiplier pair computes F, E0, E1 and E2, then three restoring dividers produce the coefficients.
// Latency: valid_out rises COEFF_WIDTH+6 cycles after accept (6 cycles for a degenerate triangle).
// Backpressure: accepts only in IDLE; the result is held in DONE until ready_in.
module barycentric_seq #(
    parameter int COORD_WIDTH = 17,
    parameter int FRAC_BITS   = 16,
    parameter int INT_BITS    = 2,
    localparam int COEFF_WIDTH = FRAC_BITS + INT_BITS
) (
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic                                    valid_in,
    output logic                                    ready_out,
    input  logic [1:0][COORD_WIDTH-1:0]             point_in,
    input  logic [2:0][1:0][COORD_WIDTH-1:0]        vertices_in,
    output logic                                    valid_out,
    input  logic                                    ready_in,
    output logic [2:0][COEFF_WIDTH-1:0]             coeffs_out,
    output logic [2:0]                              coeffs_negative_out,
    output logic                                    inside_out,
    output logic                                    degenerate_out
);
    // Coordinate differences need one extra bit. Each product needs twice that width.
    // The difference of the two products needs one bit more again.
    localparam int DW   = COORD_WIDTH + 1;
    localparam int PW   = 2 * DW;
    localparam int EW   = 2 * COORD_WIDTH + 3;
    localparam int CNTW = $clog2(COEFF_WIDTH);
    localparam logic [CNTW-1:0] DIV_LAST = CNTW'(COEFF_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_AREA, S_PREP, S_DIV, S_DONE} state_t;

    state_t                             state_q;
    logic [CNTW-1:0]                    cnt_q;
    logic [1:0][COORD_WIDTH-1:0]        pt_q;
    logic [2:0][1:0][COORD_WIDTH-1:0]   vtx_q;
    // e_q[0] = F, e_q[k+1] = Ek
    logic signed [EW-1:0]               e_q [4];
    logic [EW-1:0]                      den_q;
    logic [EW-1:0]                      rem_q [3];
    logic [COEFF_WIDTH-1:0]             num_q [3];
    logic [COEFF_WIDTH-1:0]             quo_q [3];
    logic [2:0]                         sat_q;
    logic [2:0]                         neg_q;

    logic [1:0][COORD_WIDTH-1:0]        sel_p, sel_a, sel_b;
    logic signed [DW-1:0]               dx_ba, dy_ba, dx_pa, dy_pa;
    logic signed [PW-1:0]               prod_a, prod_b;
    logic signed [EW-1:0]               edge_val;

    logic [EW-1:0]                      abs_f;
    logic [EW-1:0]                      abs_e [3];
    logic [2:0]                         sat_c;
    logic [2:0]                         neg_c;

    logic [EW:0]                        trial [3];
    logic [EW-1:0]                      rem_nx [3];
    logic [COEFF_WIDTH-1:0]             quo_nx [3];

    assign ready_out = (state_q == S_IDLE);

    // Shared multiplier pair: pick the (p, a, b) triple for the current AREA step and evaluate E(p,a,b)
    always_comb begin
        sel_p = vtx_q[0];
        sel_a = vtx_q[1];
        sel_b = vtx_q[2];
        unique case (cnt_q[1:0])
            2'd0: begin sel_p = vtx_q[0]; sel_a = vtx_q[1]; sel_b = vtx_q[2]; end
            2'd1: begin sel_p = pt_q;     sel_a = vtx_q[1]; sel_b = vtx_q[2]; end
            2'd2: begin sel_p = pt_q;     sel_a = vtx_q[2]; sel_b = vtx_q[0]; end
            default: begin sel_p = pt_q;  sel_a = vtx_q[0]; sel_b = vtx_q[1]; end
        endcase
        dx_ba    = DW'(signed'(sel_b[0])) - DW'(signed'(sel_a[0]));
        dy_ba    = DW'(signed'(sel_b[1])) - DW'(signed'(sel_a[1]));
        dx_pa    = DW'(signed'(sel_p[0])) - DW'(signed'(sel_a[0]));
        dy_pa    = DW'(signed'(sel_p[1])) - DW'(signed'(sel_a[1]));
        prod_a   = PW'(dx_ba) * PW'(dy_pa);
        prod_b   = PW'(dy_ba) * PW'(dx_pa);
        edge_val = EW'(prod_a) - EW'(prod_b);
    end

    // Magnitudes, sign and saturation flags used when loading the dividers
    always_comb begin
        abs_f = e_q[0][EW-1] ? EW'(-e_q[0]) : e_q[0];
        for (int k = 0; k < 3; k++) begin
            abs_e[k] = e_q[k+1][EW-1] ? EW'(-e_q[k+1]) : e_q[k+1];
            // Quotient needs more than INT_BITS integer bits exactly when |Ek| >= |F| * 2^INT_BITS
            sat_c[k] = {{INT_BITS{1'b0}}, abs_e[k]} >= {abs_f, {INT_BITS{1'b0}}};
            neg_c[k] = (e_q[k+1] != '0) && (e_q[k+1][EW-1] ^ e_q[0][EW-1]);
        end
    end

    // One restoring-division step per channel. A saturated channel shifts in ones regardless of the remainder.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            trial[k] = {rem_q[k], num_q[k][COEFF_WIDTH-1]};
            if (trial[k] >= {1'b0, den_q}) begin
                rem_nx[k] = EW'(trial[k] - {1'b0, den_q});
                quo_nx[k] = (quo_q[k] << 1) | COEFF_WIDTH'(1);
            end else begin
                rem_nx[k] = trial[k][EW-1:0];
                quo_nx[k] = (quo_q[k] << 1) | COEFF_WIDTH'(sat_q[k]);
            end
        end
    end

    // Control FSM and datapath registers; all outputs are registered
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q             <= S_IDLE;
            cnt_q               <= '0;
            pt_q                <= '0;
            vtx_q               <= '0;
            den_q               <= '0;
            sat_q               <= '0;
            neg_q               <= '0;
            for (int k = 0; k < 4; k++) e_q[k] <= '0;
            for (int k = 0; k < 3; k++) begin
                rem_q[k] <= '0;
                num_q[k] <= '0;
                quo_q[k] <= '0;
            end
            valid_out           <= 1'b0;
            coeffs_out          <= '0;
            coeffs_negative_out <= '0;
            inside_out          <= 1'b0;
            degenerate_out      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (valid_in) begin
                        pt_q    <= point_in;
                        vtx_q   <= vertices_in;
                        cnt_q   <= '0;
                        state_q <= S_AREA;
                    end
                end
                S_AREA: begin
                    e_q[cnt_q[1:0]] <= edge_val;
                    if (cnt_q[1:0] == 2'd3) begin
                        cnt_q   <= '0;
                        state_q <= S_PREP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PREP: begin
                    if (e_q[0] == '0) begin
                        coeffs_out          <= '0;
                        coeffs_negative_out <= '0;
                        inside_out          <= 1'b0;
                        degenerate_out      <= 1'b1;
                        valid_out           <= 1'b1;
                        state_q             <= S_DONE;
                    end else begin
                        den_q <= abs_f;
                        sat_q <= sat_c;
                        neg_q <= neg_c;
                        for (int k = 0; k < 3; k++) begin
                            // Numerator is |Ek| * 2^FRAC_BITS. The top bits seed the remainder and the rest stream in.
                            rem_q[k] <= abs_e[k] >> INT_BITS;
                            num_q[k] <= {abs_e[k][INT_BITS-1:0], {FRAC_BITS{1'b0}}};
                            quo_q[k] <= '0;
                        end
                        cnt_q   <= '0;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    for (int k = 0; k < 3; k++) begin
                        rem_q[k] <= rem_nx[k];
                        num_q[k] <= num_q[k] << 1;
                        quo_q[k] <= quo_nx[k];
                    end
                    if (cnt_q == DIV_LAST) begin
                        for (int k = 0; k < 3; k++) coeffs_out[k] <= quo_nx[k];
                        coeffs_negative_out <= neg_q;
                        inside_out          <= ~|neg_q;
                        degenerate_out      <= 1'b0;
                        valid_out           <= 1'b1;
                        state_q             <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
